prog_loader: RTL

Byte-stream program loader for the J1 program memory. Accepts a framed byte stream (length, data, checksum) over a valid/ready handshake, assembles little-endian 16-bit words and writes them sequentially into the write port of the 8Kx16 program memory. Holds the CPU in reset until a frame is loaded and verified. Sits between the host byte source (UART receiver) and the program memory write port; the CPU fetch side reads the same memory.

---
 rtl/prog_loader_if.sv | 31 +++
 rtl/prog_loader.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write port of the J1 program loader.
interface prog_loader_if #(
    parameter int unsigned addr_width = 13
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [addr_width-1:0] mem_address;
    logic [15:0]           mem_data;
    logic                  mem_wen;

    // Host side: byte source and memory write observer
    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_address,
        input  mem_data,
        input  mem_wen
    );

    // Loader side
    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_address,
        output mem_data,
        output mem_wen
    );
endinterface

// File: rtl/prog_loader.sv
// Loads a framed byte stream (length, data, checksum) into J1 program memory
// and holds the CPU in reset until a verified frame has been written.
module prog_loader #(
    parameter int unsigned size = 'h2000
) (
    input  logic         clock,
    input  logic         reset,
    prog_loader_if.slave bus,
    input  logic         start,
    output logic         cpu_reset,
    output logic         done,
    output logic         error
);
    localparam int unsigned addr_width = $clog2(size);
    localparam int unsigned data_width = 16;
    localparam int unsigned len_width  = 16;

    localparam logic [2:0] ST_LEN_LO  = 3'd0;
    localparam logic [2:0] ST_LEN_HI  = 3'd1;
    localparam logic [2:0] ST_DATA_LO = 3'd2;
    localparam logic [2:0] ST_DATA_HI = 3'd3;
    localparam logic [2:0] ST_CSUM    = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;
    localparam logic [2:0] ST_ERROR   = 3'd6;

    logic [2:0]            state,     state_nxt;
    logic [len_width-1:0]  n_words,   n_words_nxt;
    logic [len_width-1:0]  wcnt,      wcnt_nxt;
    logic [addr_width-1:0] acnt,      acnt_nxt;
    logic [7:0]            lo_byte,   lo_byte_nxt;
    logic [7:0]            csum,      csum_nxt;
    logic [addr_width-1:0] maddr,     maddr_nxt;
    logic [data_width-1:0] mdata,     mdata_nxt;
    logic                  mwen,      mwen_nxt;
    logic                  rdy,       rdy_nxt;
    logic                  done_q,    done_nxt;
    logic                  error_q,   error_nxt;
    logic                  cpurst_q,  cpurst_nxt;
    logic                  accept;
    logic [len_width-1:0]  len_c;
    logic [len_width-1:0]  wcnt_inc;

    assign accept   = bus.rx_valid && rdy;
    assign len_c    = {bus.rx_data, n_words[7:0]};
    assign wcnt_inc = len_width'(wcnt + 1'b1);

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_nxt   = state;
        n_words_nxt = n_words;
        wcnt_nxt    = wcnt;
        acnt_nxt    = acnt;
        lo_byte_nxt = lo_byte;
        csum_nxt    = csum;
        maddr_nxt   = maddr;
        mdata_nxt   = mdata;
        mwen_nxt    = 1'b0;

        case (state)
            ST_LEN_LO: begin
                if (accept) begin
                    n_words_nxt = {8'h00, bus.rx_data};
                    state_nxt   = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    n_words_nxt = len_c;
                    wcnt_nxt    = '0;
                    acnt_nxt    = '0;
                    csum_nxt    = '0;
                    if (len_c == '0)
                        state_nxt = ST_CSUM;
                    else if (32'(len_c) > size)
                        state_nxt = ST_ERROR;
                    else
                        state_nxt = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (accept) begin
                    lo_byte_nxt = bus.rx_data;
                    csum_nxt    = 8'(csum + bus.rx_data);
                    state_nxt   = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (accept) begin
                    csum_nxt  = 8'(csum + bus.rx_data);
                    mwen_nxt  = 1'b1;
                    maddr_nxt = acnt;
                    mdata_nxt = {bus.rx_data, lo_byte};
                    acnt_nxt  = addr_width'(acnt + 1'b1);
                    wcnt_nxt  = wcnt_inc;
                    state_nxt = (wcnt_inc == n_words) ? ST_CSUM : ST_DATA_LO;
                end
            end
            ST_CSUM: begin
                if (accept)
                    state_nxt = (bus.rx_data == csum) ? ST_DONE : ST_ERROR;
            end
            ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_nxt   = ST_LEN_LO;
                    n_words_nxt = '0;
                    wcnt_nxt    = '0;
                    acnt_nxt    = '0;
                    csum_nxt    = '0;
                end
            end
            default: state_nxt = ST_LEN_LO;
        endcase

        rdy_nxt    = (state_nxt != ST_DONE) && (state_nxt != ST_ERROR);
        done_nxt   = (state_nxt == ST_DONE);
        error_nxt  = (state_nxt == ST_ERROR);
        cpurst_nxt = (state_nxt != ST_DONE);
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_LEN_LO;
            n_words  <= '0;
            wcnt     <= '0;
            acnt     <= '0;
            lo_byte  <= '0;
            csum     <= '0;
            maddr    <= '0;
            mdata    <= '0;
            mwen     <= 1'b0;
            rdy      <= 1'b1;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            cpurst_q <= 1'b1;
        end else begin
            state    <= state_nxt;
            n_words  <= n_words_nxt;
            wcnt     <= wcnt_nxt;
            acnt     <= acnt_nxt;
            lo_byte  <= lo_byte_nxt;
            csum     <= csum_nxt;
            maddr    <= maddr_nxt;
            mdata    <= mdata_nxt;
            mwen     <= mwen_nxt;
            rdy      <= rdy_nxt;
            done_q   <= done_nxt;
            error_q  <= error_nxt;
            cpurst_q <= cpurst_nxt;
        end
    end

    assign bus.rx_ready    = rdy;
    assign bus.mem_address = maddr;
    assign bus.mem_data    = mdata;
    assign bus.mem_wen     = mwen;
    assign done            = done_q;
    assign error           = error_q;
    assign cpu_reset       = cpurst_q;
endmodule
